// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch-stage bus bundle: imem request/response, decoder handshake, redirect
// fetch_fault exists only when IFU_MISALIGN_CHECK_EN is defined.
interface ifu_fetch_if #(
    parameter int XLEN   = 64,
    parameter int INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   inst_pc;

    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

`ifdef IFU_MISALIGN_CHECK_EN
    logic              fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fetch_fault
    );
`else
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc
    );
`endif

endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: owns the PC, one outstanding imem fetch, redirect handling
// Optional misaligned-redirect fault state enabled by IFU_MISALIGN_CHECK_EN.
module ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter int              INST_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    ifu_fetch_if.master   bus
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              drop_q, drop_d;
    logic [XLEN-1:0]   redirect_tgt;
    logic              misaligned;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned   = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = {bus.redirect_pc[XLEN-1:2], 2'b00};
`else
    assign misaligned   = 1'b0;
    assign redirect_tgt = {bus.redirect_pc[XLEN-1:2], bus.redirect_pc[1:0] & 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        drop_d  = drop_q;

        case (state_q)
            S_REQ: begin
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                    // The old-address request still goes out; its response must be discarded.
                    if (bus.imem_req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (bus.imem_resp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (bus.imem_resp_valid) begin
                    if (drop_q) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        inst_d  = bus.imem_resp_data;
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // A redirect kills the held instruction even if the decoder takes it now.
                if (bus.redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (bus.inst_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_REQ;
            end
        endcase

        if (misaligned && (state_q != S_FAULT)) begin
            pc_d    = bus.redirect_pc;
            state_d = S_FAULT;
            drop_d  = 1'b0;
        end
    end

    assign bus.imem_req_valid = !rst && (state_q == S_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = !rst && (state_q == S_HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = pc_q;

`ifdef IFU_MISALIGN_CHECK_EN
    assign bus.fetch_fault    = !rst && (state_q == S_FAULT);
`endif

endmodule
